// File: rtl/wait_mem_if.sv
// Handshaked memory bus between the multi-cycle core (master) and a
// wait-state memory responder (slave).
interface wait_mem_if;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (output req, we, a, wd, input rd, ready, err, busy);
  modport slave  (input req, we, a, wd, output rd, ready, err, busy);
endinterface

// File: rtl/wait_mem.sv
// Wait-state memory responder: accepts one access in IDLE, waits LATENCY
// cycles, performs the word read/write and pulses ready for one cycle.
module wait_mem #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic       clk,
  input logic       reset,
  wait_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT       stateReg;
  logic [3:0]  cntReg;
  logic [29:0] addrReg;
  logic        weReg;
  logic [31:0] wdReg;
  logic        readyReg;
  logic        errReg;
  logic        busyReg;
  logic        rdSelReg;

  logic [31:0] ram [DEPTH];
  logic [31:0] ramQ;

  logic          accEn;
  logic          accWe;
  logic [29:0]   accAddr;
  logic [31:0]   accWd;
  logic          accOor;
  logic [AW-1:0] accIdx;
  logic          unusedBits;

  if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
    $error("wait_mem: LATENCY=%0d is outside 1..15", LATENCY);
  end
  if (DEPTH < 4 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
    $error("wait_mem: DEPTH=%0d is not a power of two in 4..4096", DEPTH);
  end

  // The access fires on the edge that enters RESP; with LATENCY=1 that is
  // the accept edge itself, so the live bus values are used directly.
  if (LATENCY == 1) begin : gDirect
    assign accEn   = (stateReg == IDLE) && bus.req && !reset;
    assign accWe   = bus.we;
    assign accAddr = bus.a[31:2];
    assign accWd   = bus.wd;
  end else begin : gWait
    assign accEn   = (stateReg == WAIT) && (cntReg == 4'd1) && !reset;
    assign accWe   = weReg;
    assign accAddr = addrReg;
    assign accWd   = wdReg;
  end

  assign accIdx     = accAddr[AW-1:0];
  assign accOor     = |accAddr[29:AW];
  assign unusedBits = ^{bus.a[1:0], weReg, wdReg, addrReg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= 4'd0;
      addrReg  <= 30'd0;
      weReg    <= 1'b0;
      wdReg    <= 32'd0;
      readyReg <= 1'b0;
      errReg   <= 1'b0;
      busyReg  <= 1'b0;
      rdSelReg <= 1'b0;
    end else begin
      readyReg <= 1'b0;
      errReg   <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (bus.req) begin
            addrReg <= bus.a[31:2];
            weReg   <= bus.we;
            wdReg   <= bus.wd;
            busyReg <= 1'b1;
            if (LATENCY == 1) begin
              stateReg <= RESP;
            end else begin
              stateReg <= WAIT;
              cntReg   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cntReg <= cntReg - 4'd1;
          if (cntReg == 4'd1) begin
            stateReg <= RESP;
          end
        end
        RESP: begin
          stateReg <= IDLE;
          busyReg  <= 1'b0;
        end
        default: stateReg <= IDLE;
      endcase

      if (accEn) begin
        readyReg <= 1'b1;
        errReg   <= accOor;
        // An out-of-range read forces rd to zero until the next read.
        if (!accWe) begin
          rdSelReg <= !accOor;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accEn && !accOor) begin
      if (accWe) begin
        ram[accIdx] <= accWd;
      end else begin
        ramQ <= ram[accIdx];
      end
    end
  end

  assign bus.rd    = rdSelReg ? ramQ : 32'd0;
  assign bus.ready = readyReg;
  assign bus.err   = errReg;
  assign bus.busy  = busyReg;
endmodule

// File: tb/tb_wait_mem.sv
// Directed bench for wait_mem: five instances with different latencies share
// one request stream; ready timing, data and error flags are checked per instance.
module tb_wait_mem;
  localparam int NDUT = 5;
  localparam int LATS [NDUT] = '{1, 2, 4, 5, 15};
  localparam int NV = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] wd = 32'd0;

  logic [NDUT-1:0] readyV;
  logic [NDUT-1:0] errV;
  logic [NDUT-1:0] busyV;
  logic [31:0]     rdV [NDUT];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : gDut
    wait_mem_if bus ();
    assign bus.req     = req;
    assign bus.we      = we;
    assign bus.a       = a;
    assign bus.wd      = wd;
    assign readyV[gi]  = bus.ready;
    assign errV[gi]    = bus.err;
    assign busyV[gi]   = bus.busy;
    assign rdV[gi]     = bus.rd;
    wait_mem #(.DEPTH(64), .LATENCY(LATS[gi])) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] expRd;
    logic        expErr;
  } vecT;

  vecT vec [NV];

  int nChecks = 0;
  int nPass = 0;

  int          readyAt  [NDUT];
  int          pulses   [NDUT];
  int          busyBad  [NDUT];
  int          errStray [NDUT];
  logic        errAt    [NDUT];
  logic [31:0] rdAt     [NDUT];
  logic [31:0] rdAfter  [NDUT];

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s dut%0d(L=%0d): got 0x%08h required 0x%08h", name, k, LATS[k], got, exp);
  endtask

  // One access; edge 1 is the accept edge. Optional second req pulse sampled at edge pulse2+1.
  task automatic runTxn(input logic w, input logic [31:0] ad, input logic [31:0] d, input int pulse2);
    for (int k = 0; k < NDUT; k++) begin
      readyAt[k] = -1; pulses[k] = 0; busyBad[k] = 0; errStray[k] = 0;
      errAt[k] = 1'bx; rdAt[k] = 'x; rdAfter[k] = 'x;
    end
    @(negedge clk);
    req = 1'b1; we = w; a = ad; wd = d;
    for (int e = 1; e <= 18; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        req = 1'b0; we = 1'($urandom); a = $urandom; wd = $urandom;
      end
      if (pulse2 != 0 && e == pulse2) begin
        req = 1'b1; we = 1'b0; a = 32'h4;
      end
      if (pulse2 != 0 && e == pulse2 + 1) req = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
        if (readyAt[k] >= 0 && e == readyAt[k] + 1) rdAfter[k] = rdV[k];
        if (readyAt[k] < 0 && !busyV[k]) busyBad[k]++;
        if (errV[k] && !readyV[k]) errStray[k]++;
        if (readyV[k]) begin
          pulses[k]++;
          if (readyAt[k] < 0) begin
            readyAt[k] = e; errAt[k] = errV[k]; rdAt[k] = rdV[k];
          end
        end
      end
    end
  endtask

  initial begin
    int mask;
    int settled;

    vec[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vec[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vec[2] = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0};
    vec[3] = '{1'b1, 32'h0000_0100, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1};
    vec[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    vec[5] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vec[6] = '{1'b1, 32'h0000_00FC, 32'h0BAD_CAFE, 32'h0000_0000, 1'b0};
    vec[7] = '{1'b0, 32'h0000_00FD, 32'h0000_0000, 32'h0BAD_CAFE, 1'b0};
    vec[8] = '{1'b1, 32'h0000_0008, 32'h1111_1111, 32'h0BAD_CAFE, 1'b0};
    vec[9] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'h1111_1111, 1'b0};

    // Reset for 3 cycles, then 10 idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) begin
        check("idle_ready", k, 32'(readyV[k]), 32'd0);
        check("idle_err", k, 32'(errV[k]), 32'd0);
        check("idle_busy", k, 32'(busyV[k]), 32'd0);
        check("idle_rd", k, rdV[k], 32'd0);
      end
    end
    $display("idle: 10 cycles after reset checked");

    for (int i = 0; i < NV; i++) begin
      runTxn(vec[i].we, vec[i].a, vec[i].wd, 0);
      for (int k = 0; k < NDUT; k++) begin
        check("latency", k, 32'(readyAt[k]), 32'(LATS[k]));
        check("pulses", k, 32'(pulses[k]), 32'd1);
        check("err", k, 32'(errAt[k]), 32'(vec[i].expErr));
        check("rd", k, rdAt[k], vec[i].expRd);
        check("rd_hold", k, rdAfter[k], vec[i].expRd);
        check("busy", k, 32'(busyBad[k]), 32'd0);
        check("err_stray", k, 32'(errStray[k]), 32'd0);
      end
      $display("vec %0d: %s a=0x%08h wd=0x%08h exp rd=0x%08h err=%0b", i, vec[i].we ? "WR" : "RD",
               vec[i].a, vec[i].wd, vec[i].expRd, vec[i].expErr);
    end

    // Read of 0x0 with a second req pulse sampled at edge 3; only L=1 is idle by then.
    runTxn(1'b0, 32'h0, 32'h0, 2);
    for (int k = 0; k < NDUT; k++) begin
      check("busy_req_latency", k, 32'(readyAt[k]), 32'(LATS[k]));
      check("busy_req_pulses", k, 32'(pulses[k]), (k == 0) ? 32'd2 : 32'd1);
      if (k != 0) check("busy_req_rd", k, rdAfter[k], 32'hA5A5_A5A5);
    end
    $display("busy_req: read 0x0 with extra req during WAIT");

    // Held req on the L=2 instance: accepts at edges 1, 4, 7, ready after 2, 5, 8.
    @(negedge clk);
    req = 1'b1; we = 1'b0; a = 32'h10;
    mask = 0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      if (readyV[1]) mask |= (1 << e);
    end
    req = 1'b0;
    check("held_req_mask", 1, 32'(mask), 32'h0000_0124);
    check("held_req_rd", 1, rdV[1], 32'hDEAD_BEEF);
    settled = 0;
    for (int c = 0; c < 40 && !settled; c++) begin
      @(posedge clk); #1;
      if (busyV == '0) settled = 1;
    end
    check("settle", 0, 32'(settled), 32'd1);
    $display("held_req: req held 9 edges, ready mask=0x%03h", mask);

    // Write 0xCAFEF00D to 0x8, reset 2 cycles after accept.
    @(negedge clk);
    req = 1'b1; we = 1'b1; a = 32'h8; wd = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req = 1'b0;
    mask = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("rst_busy", k, 32'(busyV[k]), 32'd0);
      check("rst_rd", k, rdV[k], 32'd0);
    end
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      for (int k = 2; k < NDUT; k++) if (readyV[k]) mask |= (1 << k);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk); #1;
      for (int k = 2; k < NDUT; k++) if (readyV[k]) mask |= (1 << k);
    end
    check("rst_no_ready", 0, 32'(mask), 32'd0);
    runTxn(1'b0, 32'h8, 32'h0, 0);
    for (int k = 0; k < NDUT; k++) begin
      check("rst_read_latency", k, 32'(readyAt[k]), 32'(LATS[k]));
      check("rst_read_rd", k, rdAt[k], (k < 2) ? 32'hCAFE_F00D : 32'h1111_1111);
    end
    $display("reset_mid: write 0xCAFEF00D to 0x8 abandoned on L>=4 instances");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/wait_mem.md
Name: wait_mem

Overview:
Wait-state memory responder for the shared instruction/data memory bus. The processor initiates each access with a req strobe. This block captures the access, waits a programmable number of cycles, then performs the read or write on its internal word RAM. It signals completion with a one-cycle ready pulse. It is the responder end of the handshaked bus used by the multi-cycle core when memory is not single-cycle.

Parameters:
DEPTH, 64, number of 32-bit words in the RAM; power of two, 4..4096
LATENCY, 2, cycles from request accept to ready; legal range 1..15

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
req  input  1  access request (level); sampled only in IDLE
we  input  1  1 = write, 0 = read; captured with req
a  input  32  byte address; bits [1:0] ignored (word access only)
wd  input  32  write data; captured with req
rd  output  32  read data; valid while ready=1, held until the next read completes
ready  output  1  one-cycle completion pulse
err  output  1  out-of-range flag; valid with ready
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, ready=0, err=0, rd=0, busy=0, latency counter=0. Captured a/we/wd registers are cleared. RAM contents are not reset.
- Reset mid-operation: an in-flight access is abandoned. A pending write is NOT performed, and no ready is issued.
- State machine: three states, IDLE, WAIT and RESP.
  - IDLE: at a clock edge with req=1, capture a[31:2], we and wd.
    - If LATENCY=1, go to RESP.
    - Otherwise go to WAIT and load counter=LATENCY-1.
  - WAIT: decrement the counter each edge. At the edge where counter==1, go to RESP.
  - RESP: ready=1 and busy=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- Timing: ready rises exactly LATENCY edges after the accept edge.
  - Minimum spacing between accepts is LATENCY+1 cycles.
  - req is ignored in WAIT and RESP; no queueing.
  - An initiator holding req high through RESP gets a new accept on the first IDLE edge.
- Access execution: the access happens at the edge that enters RESP.
  - Read: rd <= RAM[index], registered.
  - Write: RAM[index] <= wd. rd keeps its previous value.
  - A read of a word written by an earlier access returns the new data; there are no hazards because accesses are serialized.
- Address decode: index = captured a[log2(DEPTH)+1:2].
  - If captured a[31:2] >= DEPTH, err=1 during RESP.
  - On an out-of-range write, the write is suppressed.
  - On an out-of-range read, rd is driven to 0.
  - err is 0 in all other cycles.
- Signal changes: inputs a, we and wd may change after the accept edge without effect. rd changes only at the edge entering RESP of a read, or on reset.
- Counter: 4 bits, never wraps, because LATENCY ≤ 15.
- Parameter check: LATENCY outside 1..15 or a non-power-of-two DEPTH is a configuration error. Flag it with a simulation-time check.

Test Plan:
- Reset then idle: assert reset for 3 cycles, hold req=0 for 10 cycles -> ready=0, err=0, busy=0, rd=0 throughout.
- Write then read, LATENCY=2: write a=0x10, wd=0xDEADBEEF -> ready high 2 edges after accept, err=0. Then read a=0x10 -> ready after 2 edges, rd=0xDEADBEEF, and rd holds that value after ready drops.
- Latency sweep: LATENCY=1, 5 and 15 -> ready pulse occurs exactly 1, 5 and 15 edges after accept, one cycle wide. busy is high from accept through RESP.
- Request while busy: accept a read of 0x0, pulse req with a=0x4 during WAIT -> only one ready pulse, rd=RAM[0]. A held req is accepted on the first IDLE cycle after RESP.
- Out of range, DEPTH=64: write a=0x100 with wd=0x1234 -> ready with err=1. Then read a=0x0 -> RAM[0] unchanged. Read a=0x100 -> err=1, rd=0.
- Reset mid-operation: accept a write of 0xCAFEF00D to a=0x8 with LATENCY=4, assert reset after 2 cycles -> no ready pulse, and a subsequent read of 0x8 returns the prior contents.
